// File: rtl/level_meter_env_if.sv
// Sample/level bus between the sample source, the envelope follower and the
// bar-graph driver.
interface level_meter_env_if;
    logic signed [7:0] sample_in;
    logic              sample_valid;
    logic              clear;
    logic [7:0]        level;
    logic [7:0]        peak;
    logic              peak_hold_active;
    logic              overload;

    modport master (
        output sample_in, sample_valid, clear,
        input  level, peak, peak_hold_active, overload
    );

    modport slave (
        input  sample_in, sample_valid, clear,
        output level, peak, peak_hold_active, overload
    );
endinterface

// File: rtl/level_meter_env.sv
// Envelope follower with fast attack / linear decay plus a hold-then-fall peak
// marker, producing 8-bit level words for the LED bar-graph driver.
module level_meter_env #(
    parameter int DECAY_DIV  = 50000,
    parameter int DECAY_STEP = 1,
    parameter int PEAK_STEP  = 4,
    parameter int HOLD_TICKS = 500
) (
    input logic             clk,
    input logic             rst,
    level_meter_env_if.slave bus
);
    localparam int DATA_W = 8;
    localparam int TW     = $clog2(DECAY_DIV);
    localparam int HW     = $clog2(HOLD_TICKS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(DECAY_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
    localparam logic [7:0]    DSTEP     = 8'(DECAY_STEP);
    localparam logic [7:0]    PSTEP     = 8'(PEAK_STEP);

    typedef enum logic [1:0] {TRACK, HOLD, FALL} state_t;

    // |s| scaled to the full 0..255 range; -128 folds onto +127 so both
    // full-scale polarities map to 255.
    function automatic logic [7:0] mag_sat(input logic signed [DATA_W-1:0] s);
        logic [7:0] m;
        if (s == -8'sd128)
            m = 8'd127;
        else if (s < 8'sd0)
            m = 8'(-s);
        else
            m = 8'(s);
        return (m == 8'd127) ? 8'd255 : {m[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : 8'd0;
    endfunction

    logic [TW-1:0] tick_cnt_p1;
    logic [HW-1:0] hold_cnt_p1, hold_cnt_nx;
    logic [7:0]    level_p1, level_nx;
    logic [7:0]    peak_p1, peak_nx;
    logic [7:0]    mag8_p0, fall_p0;
    logic          overload_p1;
    logic          tick_p0, restart_p0, full_p0;
    state_t        state_p1, state_nx;

    // Stage 0: combinational decisions from the current sample and state
    always_comb begin
        mag8_p0    = mag_sat(bus.sample_in);
        tick_p0    = (tick_cnt_p1 == TICK_LAST);
        full_p0    = bus.sample_valid &&
                     ((bus.sample_in == -8'sd128) || (bus.sample_in == 8'sd127));
        restart_p0 = bus.sample_valid && (mag8_p0 != 8'd0) && (mag8_p0 >= peak_p1);
        fall_p0    = sat_sub(peak_p1, PSTEP);

        level_nx = level_p1;
        if (bus.sample_valid && (mag8_p0 >= level_p1))
            level_nx = mag8_p0;
        else if (tick_p0)
            level_nx = sat_sub(level_p1, DSTEP);

        state_nx    = state_p1;
        peak_nx     = peak_p1;
        hold_cnt_nx = hold_cnt_p1;
        if (restart_p0) begin
            state_nx    = HOLD;
            peak_nx     = mag8_p0;
            hold_cnt_nx = '0;
        end else begin
            case (state_p1)
                TRACK: peak_nx = level_nx;
                HOLD: begin
                    if (tick_p0) begin
                        if (hold_cnt_p1 == HOLD_LAST)
                            state_nx = FALL;
                        else
                            hold_cnt_nx = hold_cnt_p1 + HW'(1);
                    end
                end
                FALL: begin
                    if (tick_p0) begin
                        if (fall_p0 <= level_nx) begin
                            peak_nx  = level_nx;
                            state_nx = TRACK;
                        end else begin
                            peak_nx = fall_p0;
                        end
                    end
                end
                default: state_nx = TRACK;
            endcase
        end
    end

    // Stage 1: registered outputs, tick phase and peak FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_p1 <= '0;
            hold_cnt_p1 <= '0;
            level_p1    <= 8'd0;
            peak_p1     <= 8'd0;
            overload_p1 <= 1'b0;
            state_p1    <= TRACK;
        end else if (bus.clear) begin
            tick_cnt_p1 <= '0;
            hold_cnt_p1 <= '0;
            level_p1    <= 8'd0;
            peak_p1     <= 8'd0;
            overload_p1 <= 1'b0;
            state_p1    <= TRACK;
        end else begin
            tick_cnt_p1 <= tick_p0 ? '0 : tick_cnt_p1 + TW'(1);
            hold_cnt_p1 <= hold_cnt_nx;
            level_p1    <= level_nx;
            peak_p1     <= peak_nx;
            overload_p1 <= overload_p1 | full_p0;
            state_p1    <= state_nx;
        end
    end

    assign bus.level            = level_p1;
    assign bus.peak             = peak_p1;
    assign bus.peak_hold_active = (state_p1 == HOLD);
    assign bus.overload         = overload_p1;
endmodule

// File: tb/tb_level_meter_env.sv
// Randomized and directed bench for level_meter_env against a cycle-level
// behavioural model of the envelope, peak-hold and overload rules.
module tb_level_meter_env;
    localparam int DECAY_DIV  = 4;
    localparam int DECAY_STEP = 1;
    localparam int PEAK_STEP  = 4;
    localparam int HOLD_TICKS = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    level_meter_env_if bus ();

    level_meter_env #(
        .DECAY_DIV (DECAY_DIV),
        .DECAY_STEP(DECAY_STEP),
        .PEAK_STEP (PEAK_STEP),
        .HOLD_TICKS(HOLD_TICKS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: mode 0 = following level, 1 = frozen, 2 = falling
    int m_level, m_peak, m_mode, m_hticks, m_phase, m_ovl;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_reset();
        m_level = 0; m_peak = 0; m_mode = 0; m_hticks = 0; m_phase = 0; m_ovl = 0;
    endtask

    task automatic model_step(input bit v, input logic signed [7:0] s, input bit c);
        int sv, m, mag, nl, p;
        bit tick, restart;
        if (c) begin
            model_reset();
            return;
        end
        sv = s;
        m = (sv < 0) ? -sv : sv;
        if (m > 127) m = 127;
        mag = (m == 127) ? 255 : 2 * m;
        tick = (m_phase == DECAY_DIV - 1);
        m_phase = (m_phase + 1) % DECAY_DIV;

        nl = m_level;
        if (v && mag >= m_level) nl = mag;
        else if (tick) nl = (m_level - DECAY_STEP < 0) ? 0 : m_level - DECAY_STEP;

        restart = v && (mag != 0) && (mag >= m_peak);
        if (restart) begin
            m_peak = mag; m_mode = 1; m_hticks = 0;
        end else if (m_mode == 0) begin
            m_peak = nl;
        end else if (m_mode == 1 && tick) begin
            m_hticks++;
            if (m_hticks == HOLD_TICKS) m_mode = 2;
        end else if (m_mode == 2 && tick) begin
            p = (m_peak - PEAK_STEP < 0) ? 0 : m_peak - PEAK_STEP;
            if (p <= nl) begin
                m_peak = nl; m_mode = 0;
            end else begin
                m_peak = p;
            end
        end
        if (v && (s == 8'sh80 || s == 8'sh7F)) m_ovl = 1;
        m_level = nl;
    endtask

    task automatic step(input bit v, input logic [7:0] s, input bit c);
        bus.sample_valid = v;
        bus.sample_in    = s;
        bus.clear        = c;
        @(posedge clk);
        model_step(v, s, c);
        #1;
        bus.sample_valid = 1'b0;
        bus.clear        = 1'b0;
        check("level", int'(bus.level), m_level);
        check("peak", int'(bus.peak), m_peak);
        check("hold_active", int'(bus.peak_hold_active), int'(m_mode == 1));
        check("overload", int'(bus.overload), m_ovl);
        check("peak_ge_level", int'(bus.peak >= bus.level), 1);
    endtask

    task automatic idle_until_tick();
        for (int i = 0; i < DECAY_DIV && m_phase != DECAY_DIV - 1; i++)
            step(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rs;
        bus.sample_in = 8'h00;
        bus.sample_valid = 1'b0;
        bus.clear = 1'b0;
        model_reset();
        #12;
        check("rst_level", int'(bus.level), 0);
        check("rst_peak", int'(bus.peak), 0);
        check("rst_hold", int'(bus.peak_hold_active), 0);
        check("rst_ovl", int'(bus.overload), 0);
        @(negedge clk);
        rst = 1'b0;

        // Attack
        step(1'b1, 8'hC0, 1'b0);
        check("atk_level", int'(bus.level), 8'h80);
        check("atk_peak", int'(bus.peak), 8'h80);
        check("atk_hold", int'(bus.peak_hold_active), 1);
        check("atk_ovl", int'(bus.overload), 0);

        // Decay, hold, fall, then track down to zero
        for (int i = 0; i < 4 * 140; i++) step(1'b0, 8'h00, 1'b0);
        check("decay_level0", int'(bus.level), 0);
        check("decay_peak0", int'(bus.peak), 0);
        check("decay_track", int'(bus.peak_hold_active), 0);

        // Saturation, overload, clear vs sample
        step(1'b1, 8'h80, 1'b0);
        check("sat_level", int'(bus.level), 8'hFF);
        check("sat_peak", int'(bus.peak), 8'hFF);
        check("sat_ovl", int'(bus.overload), 1);
        step(1'b1, 8'h7F, 1'b0);
        check("sat7f_level", int'(bus.level), 8'hFF);
        step(1'b1, 8'h40, 1'b1);
        check("clr_level", int'(bus.level), 0);
        check("clr_peak", int'(bus.peak), 0);
        check("clr_ovl", int'(bus.overload), 0);
        check("clr_hold", int'(bus.peak_hold_active), 0);

        // Small sample on a tick cycle is ignored, decay still applies
        step(1'b1, 8'h20, 1'b0);
        idle_until_tick();
        check("coll_pre", int'(bus.level), 8'h40);
        step(1'b1, 8'h10, 1'b0);
        check("coll_level", int'(bus.level), 8'h3F);

        // Restart from FALL on a tick
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h28, 1'b0);
        for (int i = 0; i < 40 && m_mode != 2; i++) step(1'b0, 8'h00, 1'b0);
        check("fall_reached", m_mode, 2);
        idle_until_tick();
        step(1'b1, 8'h28, 1'b0);
        check("rst_fall_level", int'(bus.level), 8'h50);
        check("rst_fall_peak", int'(bus.peak), 8'h50);
        check("rst_fall_hold", int'(bus.peak_hold_active), 1);
        for (int i = 0; i < 30; i++) step(1'b0, 8'h00, 1'b0);

        // Zero input never enters HOLD
        step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'h00, 1'b0);
            check("zero_hold", int'(bus.peak_hold_active), 0);
        end

        // Asynchronous reset in HOLD, then tick phase restarts
        step(1'b1, 8'hC0, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_level", int'(bus.level), 0);
        check("arst_peak", int'(bus.peak), 0);
        check("arst_hold", int'(bus.peak_hold_active), 0);
        check("arst_ovl", int'(bus.overload), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 8'h20, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check("phase_before", int'(bus.level), 8'h40);
        step(1'b0, 8'h00, 1'b0);
        check("phase_tick", int'(bus.level), 8'h3F);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            rs = 8'($urandom);
            case ($urandom_range(0, 9))
                0: rs = 8'h80;
                1: rs = 8'h7F;
                2: rs = 8'h00;
                default: ;
            endcase
            step(($urandom_range(0, 5) == 0), rs, ($urandom_range(0, 299) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
